// File: rtl/pipe_reg_chain.sv
// Elastic valid/ready register chain: WIDTH-bit beats through DEPTH stages with bubble collapsing.
// Define PIPE_REG_FLUSH_EN to add the synchronous flush_i port.
module pipe_reg_chain #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
`ifdef PIPE_REG_FLUSH_EN
  input  logic                       flush_i,
`endif
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q, valid_d, move;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic             flush;

`ifdef PIPE_REG_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // A stage may load when it is empty or everything downstream of it is moving.
  always_comb begin
    logic m;
    move          = '0;
    m             = ready_i || !valid_q[DEPTH-1];
    move[DEPTH-1] = m;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      m       = m || !valid_q[k];
      move[k] = m;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (move[0]) begin
      valid_d[0] = valid_i;
      if (valid_i) data_d[0] = data_i;
    end
    for (int k = 1; k < int'(DEPTH); k++) begin
      if (move[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) data_d[k] = data_q[k-1];
      end
    end
    // Flush drops every beat but leaves the data registers untouched.
    if (flush) begin
      valid_d = '0;
      data_d  = data_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) data_q[k] <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    occupancy_o = '0;
    for (int k = 0; k < int'(DEPTH); k++) occupancy_o = occupancy_o + OccW'(valid_q[k]);
  end

  assign ready_o = move[0] && !flush;
  assign valid_o = valid_q[DEPTH-1] && !flush;
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain: directed scenarios plus random traffic,
// with a FIFO scoreboard monitor checking every cycle.
module tb_pipe_reg_chain;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 3;
  localparam logic [7:0]  RV    = 8'hA5;

  logic       clk = 1'b0;
  logic       reset_ni = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_i = 1'b0;
  logic       flush_i = 1'b0;
  logic [7:0] data_i = '0;
  logic       ready_o, valid_o;
  logic [7:0] data_o;
  logic [1:0] occupancy_o;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         n;

  always #5 clk = ~clk;

  pipe_reg_chain #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_VAL(RV)
  ) dut (
    .clk_i      (clk),
    .reset_ni   (reset_ni),
`ifdef PIPE_REG_FLUSH_EN
    .flush_i    (flush_i),
`endif
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .occupancy_o(occupancy_o)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    valid_i = v;
    data_i  = d;
  endtask

  // Scoreboard: the chain is a FIFO of capacity DEPTH; it can accept whenever it is
  // not full or the output is draining.
  always @(negedge clk) begin
    if (!reset_ni) begin
      exp_q.delete();
    end else begin
      n = exp_q.size();
      chk("occupancy", 32'(occupancy_o), n);
      chk("ready_o", 32'(ready_o), 32'((n < int'(DEPTH) || ready_i) && !flush_i));
      if (flush_i || n == 0) chk("valid_o_idle", 32'(valid_o), 0);
      else if (valid_o) chk("data_o_head", 32'(data_o), 32'(exp_q[0]));
      if (flush_i) begin
        exp_q.delete();
      end else begin
        if (valid_o && ready_i && n > 0) void'(exp_q.pop_front());
        if (valid_i && ready_o) exp_q.push_back(data_i);
      end
    end
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_data", 32'(data_o), 32'(RV));
    chk("rst_occ", 32'(occupancy_o), 0);
    chk("rst_ready", 32'(ready_o), 1);
    reset_ni = 1'b1;

    // Latency and throughput
    ready_i = 1'b1;
    for (int i = 0; i < 16 + int'(DEPTH); i++) begin
      drive(i < 16, 8'(i + 1));
      @(negedge clk);
      if (i >= int'(DEPTH)) begin
        chk("lat_valid", 32'(valid_o), 1);
        chk("lat_data", 32'(data_o), 32'(i - int'(DEPTH) + 1));
      end else begin
        chk("lat_valid", 32'(valid_o), 0);
      end
      chk("stream_ready", 32'(ready_o), 1);
      step();
    end
    drive(0, 8'h00);

    // Backpressure with a bubble
    ready_i = 1'b0;
    drive(1, 8'h11); step();
    drive(0, 8'h00); step();
    drive(1, 8'h22); step();
    drive(1, 8'h33); step();
    drive(1, 8'h44);
    @(negedge clk);
    chk("bp_occ", 32'(occupancy_o), 3);
    chk("bp_ready", 32'(ready_o), 0);
    chk("bp_valid", 32'(valid_o), 1);
    chk("bp_data", 32'(data_o), 32'h11);
    step();
    @(negedge clk);
    chk("bp_hold_data", 32'(data_o), 32'h11);
    chk("bp_hold_occ", 32'(occupancy_o), 3);
    step();
    drive(0, 8'h00);
    ready_i = 1'b1;
    got_q.delete();
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (valid_o) got_q.push_back(data_o);
      step();
    end
    chk("drain_count", 32'(got_q.size()), 3);
    if (got_q.size() == 3) begin
      chk("drain_0", 32'(got_q[0]), 32'h11);
      chk("drain_1", 32'(got_q[1]), 32'h22);
      chk("drain_2", 32'(got_q[2]), 32'h33);
    end

    // Full chain with simultaneous in/out transfers
    ready_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      drive(1, 8'(8'h61 + j)); step();
    end
    ready_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      drive(1, 8'(8'h64 + j));
      @(negedge clk);
      chk("full_occ", 32'(occupancy_o), 3);
      chk("full_ready", 32'(ready_o), 1);
      chk("full_data", 32'(data_o), 32'(8'h61 + j));
      step();
    end
    drive(0, 8'h00);
    repeat (DEPTH + 1) step();

    // Asynchronous reset mid-stream
    ready_i = 1'b0;
    drive(1, 8'h71); step();
    drive(1, 8'h72); step();
    drive(0, 8'h00);
    @(posedge clk);
    #3 reset_ni = 1'b0;
    #1;
    chk("areset_valid", 32'(valid_o), 0);
    chk("areset_occ", 32'(occupancy_o), 0);
    chk("areset_ready", 32'(ready_o), 1);
    chk("areset_data", 32'(data_o), 32'(RV));
    @(negedge clk);
    #1 reset_ni = 1'b1;
    step();
    ready_i = 1'b1;
    drive(1, 8'h5A);
    for (int i = 0; i <= int'(DEPTH); i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(valid_o), 32'(i == int'(DEPTH)));
      if (i == int'(DEPTH)) chk("post_rst_data", 32'(data_o), 32'h5A);
      step();
      drive(0, 8'h00);
    end

`ifdef PIPE_REG_FLUSH_EN
    // Flush discards held beats and the concurrent input beat
    ready_i = 1'b0;
    drive(1, 8'h01); step();
    drive(1, 8'h02); step();
    drive(0, 8'h00); step();
    flush_i = 1'b1;
    drive(1, 8'h03);
    @(negedge clk);
    chk("flush_ready", 32'(ready_o), 0);
    chk("flush_valid", 32'(valid_o), 0);
    step();
    flush_i = 1'b0;
    drive(0, 8'h00);
    chk("flush_occ", 32'(occupancy_o), 0);
    chk("flush_valid_after", 32'(valid_o), 0);
    chk("flush_data_hold", 32'(data_o), 32'h01);
    ready_i = 1'b1;
    repeat (DEPTH + 2) begin
      @(negedge clk);
      chk("flush_no_out", 32'(valid_o), 0);
      step();
    end
`endif

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom));
      ready_i = ($urandom_range(0, 2) != 0);
`ifdef PIPE_REG_FLUSH_EN
      flush_i = ($urandom_range(0, 40) == 0);
`endif
      step();
    end
    flush_i = 1'b0;
    drive(0, 8'h00);
    ready_i = 1'b1;
    repeat (DEPTH + 2) step();
    @(negedge clk);
    chk("final_occ", 32'(occupancy_o), 0);
    chk("final_sb_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
